spongent_ctrl: RTL

Sequencer and two-way arbiter that shares one SPONGENT hash core between two requesters. Grants the core to one requester per hash, clears the core state, feeds rate-sized message blocks one at a time (absorb), then issues squeeze permutations and returns the digest in rate-sized blocks. Sits directly in front of the SPONGENT core; requesters supply already-padded blocks.

---
 rtl/spongent_ctrl_pkg.sv | 26 ++
 rtl/spongent_rr_arb2.sv | 17 +
 rtl/spongent_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spongent_ctrl_pkg.sv
// Shared encodings for the SPONGENT sequencer: one-hot FSM states and
// absorb/squeeze phase constants.
package spongent_ctrl_pkg;

  localparam int STATE_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = 8'b0000_0001,
    S_CLEAR      = 8'b0000_0010,
    S_CLEAR_WAIT = 8'b0000_0100,
    S_LOAD       = 8'b0000_1000,
    S_ISSUE      = 8'b0001_0000,
    S_GUARD      = 8'b0010_0000,
    S_WAIT       = 8'b0100_0000,
    S_OUTPUT     = 8'b1000_0000
  } state_t;

  localparam logic PHASE_ABSORB  = 1'b1;
  localparam logic PHASE_SQUEEZE = 1'b0;

  // Digest-block counter width; a single-block digest still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spongent_rr_arb2.sv
// Two-way round-robin pick: the requester named by ptr wins a tie.
module spongent_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (req[ptr]) begin
      pick[ptr] = 1'b1;
    end else if (req[!ptr]) begin
      pick[!ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/spongent_ctrl.sv
// Shares one SPONGENT core between two requesters: clear, absorb the message
// block by block, then squeeze and return the digest in rate-sized blocks.
//
// state      | meaning
// IDLE       | no owner; arbitrate among in_valid
// CLEAR      | core_reset asserted for one cycle
// CLEAR_WAIT | core leaves reset
// LOAD       | accept next message block from the owner
// ISSUE      | core_start pulse (absorb or squeeze)
// GUARD      | give core_busy a cycle to rise
// WAIT       | wait for the permutation to finish
// OUTPUT     | present a digest block to the owner
module spongent_ctrl
  import spongent_ctrl_pkg::*;
#(
  parameter int RATE          = 16,
  parameter int DIGEST_BLOCKS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        in_valid,
  input  logic [1:0]        in_last,
  input  logic [2*RATE-1:0] in_data,
  output logic [1:0]        in_ready,
  output logic [1:0]        grant,
  output logic [1:0]        out_valid,
  output logic              out_last,
  output logic [RATE-1:0]   out_data,
  input  logic              out_ready,
  output logic              core_reset,
  output logic              core_start,
  output logic              core_msg_avail,
  output logic [RATE-1:0]   core_msg_data,
  input  logic              core_busy,
  input  logic [RATE-1:0]   core_digest
);

  localparam int               CNT_W    = cnt_width(DIGEST_BLOCKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGEST_BLOCKS - 1);

  state_t            state, state_nxt;
  logic              ptr, ptr_nxt;
  logic              g, g_nxt;
  logic              phase, phase_nxt;
  logic              last_r, last_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RATE-1:0]   msg_r, msg_nxt;
  logic [1:0]        pick;
  logic [1:0]        g_onehot;
  logic              sel_valid, sel_last;
  logic [RATE-1:0]   sel_data;
  logic              last_beat;
  logic              clear_fsm;

  spongent_rr_arb2 u_arb (
    .req  (in_valid),
    .ptr  (ptr),
    .pick (pick)
  );

  assign g_onehot  = g ? 2'b10 : 2'b01;
  assign sel_valid = in_valid[g];
  assign sel_last  = in_last[g];
  assign sel_data  = g ? in_data[2*RATE-1:RATE] : in_data[RATE-1:0];
  assign last_beat = (cnt == CNT_LAST);

  // Core must also be held clear while the controller itself is in reset.
  assign core_reset    = !reset_n || clear_fsm;
  assign core_msg_data = msg_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ptr    <= 1'b0;
      g      <= 1'b0;
      phase  <= PHASE_ABSORB;
      last_r <= 1'b0;
      cnt    <= '0;
      msg_r  <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      g      <= g_nxt;
      phase  <= phase_nxt;
      last_r <= last_nxt;
      cnt    <= cnt_nxt;
      msg_r  <= msg_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    g_nxt          = g;
    phase_nxt      = phase;
    last_nxt       = last_r;
    cnt_nxt        = cnt;
    msg_nxt        = msg_r;
    grant          = 2'b00;
    in_ready       = 2'b00;
    out_valid      = 2'b00;
    out_last       = 1'b0;
    out_data       = '0;
    core_start     = 1'b0;
    core_msg_avail = 1'b0;
    clear_fsm      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (|in_valid) begin
          g_nxt     = (pick == 2'b10);
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        grant     = g_onehot;
        clear_fsm = 1'b1;
        state_nxt = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: begin
        grant     = g_onehot;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        grant    = g_onehot;
        in_ready = g_onehot & {2{sel_valid}};
        if (sel_valid) begin
          msg_nxt   = sel_data;
          last_nxt  = sel_last;
          phase_nxt = PHASE_ABSORB;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        grant          = g_onehot;
        core_start     = 1'b1;
        core_msg_avail = (phase == PHASE_ABSORB);
        state_nxt      = S_GUARD;
      end
      S_GUARD: begin
        grant     = g_onehot;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        grant = g_onehot;
        if (!core_busy) begin
          if (phase == PHASE_ABSORB && !last_r) begin
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_OUTPUT;
            if (phase == PHASE_ABSORB) cnt_nxt = '0;
          end
        end
      end
      S_OUTPUT: begin
        grant     = g_onehot;
        out_valid = g_onehot;
        out_data  = core_digest;
        out_last  = last_beat;
        if (out_ready) begin
          if (last_beat) begin
            ptr_nxt   = !g;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            phase_nxt = PHASE_SQUEEZE;
            state_nxt = S_ISSUE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
